// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus 2-bit-counter BHT, with the
// fetch-time hit flags carried through ID/EX so the EX branch can be scored.
module branch_predictor #(
  parameter int BTB_IDX = 6,
  parameter int BHT_IDX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic [31:0] BranchTarget,
  input  logic        BrInstE,
  input  logic        BranchE,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic [31:0] PredictPC,
  output logic        BTB_HitF,
  output logic        BHT_HitF,
  output logic        BTB_HitE,
  output logic        BHT_HitE,
  output logic        MispredictE,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  localparam int BTB_N = 1 << BTB_IDX;
  localparam int BHT_N = 1 << BHT_IDX;
  localparam int TAG_W = 32 - BTB_IDX - 2;

  logic             btb_valid_q [BTB_N];
  logic             btb_valid_d [BTB_N];
  logic [TAG_W-1:0] btb_tag_q   [BTB_N];
  logic [TAG_W-1:0] btb_tag_d   [BTB_N];
  logic [31:0]      btb_tgt_q   [BTB_N];
  logic [31:0]      btb_tgt_d   [BTB_N];
  logic [1:0]       bht_q       [BHT_N];
  logic [1:0]       bht_d       [BHT_N];

  logic        btb_hitd_q, btb_hitd_d;
  logic        bht_hitd_q, bht_hitd_d;
  logic        btb_hite_q, btb_hite_d;
  logic        bht_hite_q, bht_hite_d;
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  logic [BTB_IDX-1:0] btb_idx_f, btb_idx_e;
  logic [TAG_W-1:0]   tag_f, tag_e;
  logic [BHT_IDX-1:0] bht_idx_f, bht_idx_e;
  logic               upd;
  logic               unused_pc_bits;

  assign btb_idx_f      = PCF[BTB_IDX+1:2];
  assign tag_f          = PCF[31:BTB_IDX+2];
  assign bht_idx_f      = PCF[BHT_IDX+1:2];
  assign btb_idx_e      = PCE[BTB_IDX+1:2];
  assign tag_e          = PCE[31:BTB_IDX+2];
  assign bht_idx_e      = PCE[BHT_IDX+1:2];
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // Fetch lookup reads the registered arrays only, so a same-cycle update is not seen.
  assign BTB_HitF  = btb_valid_q[btb_idx_f] && (btb_tag_q[btb_idx_f] == tag_f);
  assign BHT_HitF  = bht_q[bht_idx_f][1];
  assign PredictPC = BTB_HitF ? btb_tgt_q[btb_idx_f] : PCF + 32'd4;

  assign BTB_HitE    = btb_hite_q;
  assign BHT_HitE    = bht_hite_q;
  assign MispredictE = BrInstE & (BranchE ^ (btb_hite_q & bht_hite_q));
  assign BrCount     = br_count_q;
  assign MissCount   = miss_count_q;

  assign upd = BrInstE & ~StallE & ~FlushE;

  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_tgt_d    = btb_tgt_q;
    bht_d        = bht_q;
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (upd) begin
      if (BranchE) begin
        if (bht_q[bht_idx_e] != 2'b11) bht_d[bht_idx_e] = bht_q[bht_idx_e] + 2'b01;
        btb_valid_d[btb_idx_e] = 1'b1;
        btb_tag_d[btb_idx_e]   = tag_e;
        btb_tgt_d[btb_idx_e]   = BranchTarget;
      end else begin
        if (bht_q[bht_idx_e] != 2'b00) bht_d[bht_idx_e] = bht_q[bht_idx_e] - 2'b01;
      end
      br_count_d = br_count_q + 32'd1;
      if (MispredictE) miss_count_d = miss_count_q + 32'd1;
    end
  end

  // Flush beats stall in both flag stages.
  always_comb begin
    btb_hitd_d = btb_hitd_q;
    bht_hitd_d = bht_hitd_q;
    btb_hite_d = btb_hite_q;
    bht_hite_d = bht_hite_q;
    if (FlushD) begin
      btb_hitd_d = 1'b0;
      bht_hitd_d = 1'b0;
    end else if (!StallD) begin
      btb_hitd_d = BTB_HitF;
      bht_hitd_d = BHT_HitF;
    end
    if (FlushE) begin
      btb_hite_d = 1'b0;
      bht_hite_d = 1'b0;
    end else if (!StallE) begin
      btb_hite_d = btb_hitd_q;
      bht_hite_d = bht_hitd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
      end
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
      btb_hitd_q   <= 1'b0;
      bht_hitd_q   <= 1'b0;
      btb_hite_q   <= 1'b0;
      bht_hite_q   <= 1'b0;
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_tgt_q    <= btb_tgt_d;
      bht_q        <= bht_d;
      btb_hitd_q   <= btb_hitd_d;
      bht_hitd_q   <= bht_hitd_d;
      btb_hite_q   <= btb_hite_d;
      bht_hite_q   <= bht_hite_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected values are queued as each step
// is driven and popped against the DUT outputs once they have settled.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF, PCE, BranchTarget;
  logic        BrInstE, BranchE, StallD, FlushD, StallE, FlushE;
  logic [31:0] PredictPC, BrCount, MissCount;
  logic        BTB_HitF, BHT_HitF, BTB_HitE, BHT_HitE, MispredictE;

  logic [31:0] exp_q[$];
  int          n_cmp;
  int          n_miss;

  branch_predictor #(.BTB_IDX(6), .BHT_IDX(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCF          (PCF),
    .PCE          (PCE),
    .BranchTarget (BranchTarget),
    .BrInstE      (BrInstE),
    .BranchE      (BranchE),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .StallE       (StallE),
    .FlushE       (FlushE),
    .PredictPC    (PredictPC),
    .BTB_HitF     (BTB_HitF),
    .BHT_HitF     (BHT_HitF),
    .BTB_HitE     (BTB_HitE),
    .BHT_HitE     (BHT_HitE),
    .MispredictE  (MispredictE),
    .BrCount      (BrCount),
    .MissCount    (MissCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $error("FAIL %s: observed %h, expected queue empty", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_miss++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic branch(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic br, input logic taken);
    PCE = pc; BranchTarget = tgt; BrInstE = br; BranchE = taken;
  endtask

  initial begin
    n_cmp = 0; n_miss = 0;
    rst_n = 1'b0;
    PCF = 32'h100; PCE = 32'h0; BranchTarget = 32'h0;
    BrInstE = 1'b1; BranchE = 1'b1;
    StallD = 1'b0; FlushD = 1'b0; StallE = 1'b0; FlushE = 1'b0;

    // Reset state
    push(32'd0); push(32'd0); push(32'h104); push(32'd0); push(32'd0);
    push(32'd0); push(32'd0); push(32'd1);
    #3;
    chk("rst_btb_hitf", {31'd0, BTB_HitF});
    chk("rst_bht_hitf", {31'd0, BHT_HitF});
    chk("rst_predict_pc", PredictPC);
    chk("rst_br_count", BrCount);
    chk("rst_miss_count", MissCount);
    chk("rst_btb_hite", {31'd0, BTB_HitE});
    chk("rst_bht_hite", {31'd0, BHT_HitE});
    chk("rst_mispredict", {31'd0, MispredictE});
    @(negedge clk);
    BrInstE = 1'b0; BranchE = 1'b0; PCF = 32'h404;
    @(negedge clk);
    rst_n = 1'b1;

    // Train 0x100 taken twice: BHT 01->10->11, both counted as misses
    tick();
    branch(32'h100, 32'h80, 1'b1, 1'b1);
    tick(); tick();
    branch(32'h0, 32'h0, 1'b0, 1'b0);
    PCF = 32'h100;
    push(32'd1); push(32'd1); push(32'h80); push(32'd2); push(32'd2);
    #1;
    chk("train_btb_hitf", {31'd0, BTB_HitF});
    chk("train_bht_hitf", {31'd0, BHT_HitF});
    chk("train_predict_pc", PredictPC);
    chk("train_br_count", BrCount);
    chk("train_miss_count", MissCount);

    // Carry the hit flags of 0x100 into EX, then resolve not-taken
    tick();
    PCF = 32'h404;
    tick();
    push(32'd1); push(32'd1);
    chk("pipe_btb_hite", {31'd0, BTB_HitE});
    chk("pipe_bht_hite", {31'd0, BHT_HitE});
    branch(32'h100, 32'h80, 1'b1, 1'b0);
    push(32'd1);
    #1;
    chk("nt1_mispredict", {31'd0, MispredictE});
    tick();
    PCF = 32'h100;
    push(32'd1); push(32'd3); push(32'd3);
    #1;
    chk("nt1_bht_hitf_3to2", {31'd0, BHT_HitF});
    chk("nt1_br_count", BrCount);
    chk("nt1_miss_count", MissCount);
    // Second not-taken; lookup to the same index still sees the old counter
    push(32'd0); push(32'd1);
    chk("nt2_mispredict", {31'd0, MispredictE});
    chk("nt2_same_idx_lookup", {31'd0, BHT_HitF});
    tick();
    branch(32'h0, 32'h0, 1'b0, 1'b0);
    push(32'd0); push(32'd1); push(32'h80); push(32'd4); push(32'd3);
    #1;
    chk("nt2_bht_hitf_2to1", {31'd0, BHT_HitF});
    chk("nt2_btb_hitf", {31'd0, BTB_HitF});
    chk("nt2_predict_pc", PredictPC);
    chk("nt2_br_count", BrCount);
    chk("nt2_miss_count", MissCount);
    PCF = 32'h404;
    tick(); tick();

    // Alias: 0x100 then 0x200 share BTB index 0
    branch(32'h100, 32'h80, 1'b1, 1'b1);
    tick();
    branch(32'h200, 32'h300, 1'b1, 1'b1);
    tick();
    branch(32'h0, 32'h0, 1'b0, 1'b0);
    PCF = 32'h100;
    push(32'd0); push(32'h104); push(32'd1);
    #1;
    chk("alias_btb_hitf_old", {31'd0, BTB_HitF});
    chk("alias_predict_pc_old", PredictPC);
    chk("alias_bht_hitf_old", {31'd0, BHT_HitF});
    PCF = 32'h200;
    push(32'd1); push(32'h300); push(32'd6); push(32'd5);
    #1;
    chk("alias_btb_hitf_new", {31'd0, BTB_HitF});
    chk("alias_predict_pc_new", PredictPC);
    chk("alias_br_count", BrCount);
    chk("alias_miss_count", MissCount);

    // Non-branch with BranchE high must not write anything
    PCF = 32'h404;
    branch(32'h600, 32'h700, 1'b0, 1'b1);
    tick();
    branch(32'h0, 32'h0, 1'b0, 1'b0);
    PCF = 32'h600;
    push(32'd0); push(32'd1); push(32'd6);
    #1;
    chk("nonbr_btb_hitf", {31'd0, BTB_HitF});
    chk("nonbr_bht_alias_hitf", {31'd0, BHT_HitF});
    chk("nonbr_br_count", BrCount);

    // StallD/StallE hold flags; release lets the held D flags into EX
    PCF = 32'h200;
    tick();
    PCF = 32'h404; StallD = 1'b1; StallE = 1'b1;
    tick(); tick();
    push(32'd0); push(32'd0);
    chk("stall_btb_hite", {31'd0, BTB_HitE});
    chk("stall_bht_hite", {31'd0, BHT_HitE});
    StallD = 1'b0; StallE = 1'b0;
    tick();
    push(32'd1); push(32'd1);
    chk("unstall_btb_hite", {31'd0, BTB_HitE});
    chk("unstall_bht_hite", {31'd0, BHT_HitE});

    // FlushE as the flagged branch enters EX: flags cleared, no update
    PCF = 32'h200;
    tick();
    PCF = 32'h404; FlushE = 1'b1;
    branch(32'h404, 32'h500, 1'b1, 1'b1);
    tick();
    FlushE = 1'b0;
    branch(32'h0, 32'h0, 1'b0, 1'b0);
    push(32'd0); push(32'd0); push(32'd6); push(32'd0);
    #1;
    chk("flushe_btb_hite", {31'd0, BTB_HitE});
    chk("flushe_bht_hite", {31'd0, BHT_HitE});
    chk("flushe_br_count", BrCount);
    chk("flushe_btb_hitf", {31'd0, BTB_HitF});

    // FlushD wins over StallD
    PCF = 32'h200;
    tick();
    PCF = 32'h404; StallD = 1'b1; FlushD = 1'b1;
    tick();
    StallD = 1'b0; FlushD = 1'b0;
    push(32'd1);
    chk("flushd_prev_in_e", {31'd0, BTB_HitE});
    tick();
    push(32'd0);
    chk("flushd_cleared", {31'd0, BHT_HitE});

    // StallE blocks the update until it drops, then exactly one update
    StallE = 1'b1;
    branch(32'h404, 32'h500, 1'b1, 1'b1);
    tick(); tick();
    push(32'd6); push(32'd0);
    #1;
    chk("stalle_br_count", BrCount);
    chk("stalle_btb_hitf", {31'd0, BTB_HitF});
    StallE = 1'b0;
    tick();
    branch(32'h0, 32'h0, 1'b0, 1'b0);
    push(32'd7); push(32'd6); push(32'd1); push(32'h500);
    #1;
    chk("stalle_rel_br_count", BrCount);
    chk("stalle_rel_miss_count", MissCount);
    chk("stalle_rel_btb_hitf", {31'd0, BTB_HitF});
    chk("stalle_rel_predict_pc", PredictPC);

    // Asynchronous reset mid-cycle after training
    PCF = 32'h200;
    tick(); tick();
    push(32'd1);
    chk("pre_rst_btb_hite", {31'd0, BTB_HitE});
    @(posedge clk);
    #3;
    branch(32'h200, 32'h300, 1'b1, 1'b1);
    rst_n = 1'b0;
    push(32'd0); push(32'd0); push(32'd0); push(32'd0); push(32'h204);
    push(32'd0); push(32'd0); push(32'd1);
    #1;
    chk("arst_br_count", BrCount);
    chk("arst_miss_count", MissCount);
    chk("arst_btb_hitf", {31'd0, BTB_HitF});
    chk("arst_bht_hitf", {31'd0, BHT_HitF});
    chk("arst_predict_pc", PredictPC);
    chk("arst_btb_hite", {31'd0, BTB_HitE});
    chk("arst_bht_hite", {31'd0, BHT_HitE});
    chk("arst_mispredict", {31'd0, MispredictE});
    branch(32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_miss++;
      $error("FAIL leftover_expected: observed %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RISC-V pipeline: a direct-mapped BTB plus a 2-bit-counter BHT. It looks up the fetch PC in IF, returns predicted target and hit flags to the next-PC selector, and carries those flags through ID and EX alongside the branch. In EX it trains both tables and reports the resolved branch's prediction state back to the next-PC selector.

## Interface
- BTB_IDX, 6: log2 of BTB entries (64); index = PC[BTB_IDX+1:2], tag = PC[31:BTB_IDX+2]
- BHT_IDX, 8: log2 of BHT entries (256); index = PC[BHT_IDX+1:2]

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- PCF  in  32  fetch-stage PC
- PCE  in  32  PC of the instruction in EX
- BranchTarget  in  32  computed target of the EX-stage branch
- BrInstE  in  1  EX instruction is a conditional branch
- BranchE  in  1  EX branch resolved taken
- StallD, FlushD  in  1  ID pipeline-register controls
- StallE, FlushE  in  1  EX pipeline-register controls
- PredictPC  out  32  BTB target on BTB hit, else PCF+4
- BTB_HitF  out  1  BTB valid and tag match for PCF
- BHT_HitF  out  1  BHT counter[1] for PCF (predict taken)
- BTB_HitE, BHT_HitE  out  1  prediction flags of the EX instruction
- MispredictE  out  1  EX branch prediction was wrong
- BrCount  out  32  retired conditional branches
- MissCount  out  32  mispredicted conditional branches

## Operation
- IF lookup is combinational on PCF against current array contents; no write-to-read bypass.
- BTB entry: valid, tag (32-BTB_IDX-2 bits), target (32 bits). BHT entry: 2-bit saturating counter.
- Flag pipeline: BTB_HitD/BHT_HitD and BTB_HitE/BHT_HitE registers. Per stage: Flush clears both to 0; else Stall holds; else capture the previous stage. Flush has priority over Stall.
- Update enable: upd = BrInstE & ~StallE & ~FlushE.
- On upd, BHT[PCE index]: BranchE increments, saturating at 3; ~BranchE decrements, saturating at 0.
- On upd & BranchE, BTB[PCE index] is written with valid=1, tag(PCE), target=BranchTarget, overwriting any alias. A not-taken branch leaves the BTB untouched.
- MispredictE = BrInstE & (BranchE ^ (BTB_HitE & BHT_HitE)). This is combinational and not gated by stall.
- Counters, gated by upd: BrCount += 1; MissCount += 1 when MispredictE. Both wrap modulo 2^32.
- Non-branch instructions never modify the tables, even if they hit in the BTB.

## Timing
- Reset (asynchronous, any cycle, including mid-update): all BTB valid=0, all BHT counters=2'b01 (weakly not-taken), all flag registers 0, BrCount=MissCount=0.
- Outputs after reset:
  - BTB_HitF=BHT_HitF=0
  - PredictPC=PCF+4
  - BTB_HitE=BHT_HitE=0
  - MispredictE=BrInstE&BranchE
- Latency:
  - F-stage outputs: 0 cycles.
  - Flags reach EX two edges after fetch, with no stalls.
  - A table update at edge N is visible to lookups from cycle N+1.
- Simultaneous IF lookup and EX update to the same index: lookup returns the pre-update value.
- BHT aliasing across PCs sharing an index is permitted; no tag is kept for the BHT.
- Counter wrap: 32'hFFFFFFFF + 1 -> 0 without affecting the other counter.

## Test plan
- Reset then PCF=0x100: BTB_HitF=0, BHT_HitF=0, PredictPC=0x104. All counters 0.
- Branch at PCE=0x100, target 0x80, taken twice (BrInstE=BranchE=1, two upd cycles) -> BHT 01->10->11. The next PCF=0x100 gives BTB_HitF=1, BHT_HitF=1, PredictPC=0x80. BrCount=2, MissCount=2.
- With 0x100 trained strongly taken, resolve not-taken once: MispredictE=1 and MissCount increments. The counter goes 3->2, so the next lookup still predicts taken. A second not-taken gives 2->1 and BHT_HitF=0.
- Alias: PCE=0x100, then 0x200 (same BTB index with BTB_IDX=6), both taken. PCF=0x100 then gives BTB_HitF=0 (tag mismatch) and PredictPC=0x104.
- Flag pipeline: fetch with hits=1 and StallD=1 for 2 cycles; flags are held in D. Then FlushE=1 while the branch would enter EX: BTB_HitE=BHT_HitE=0 and no update occurs. Also check StallE=1 with BrInstE=1: no count or table change until StallE drops, then exactly one update.
- Assert rst_n low mid-run after training: tables, flags and counters return to reset values immediately, without waiting for a clock edge.
